// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter between NREQ byte producers.
// Optional WAIT-state abort is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        uart_in,
  output logic              uart_writestart,
  input  logic              uart_writedone,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      data_q, data_d;
  logic            wd_q;
  logic            wd_event;
  logic            expired;
  logic [IW-1:0]   win;
  logic            found;
  int              idx;

  // Only a rising edge of writedone completes a frame; stale high levels are ignored.
  assign wd_event = uart_writedone && !wd_q;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  assign expired     = (cnt_q == CW'(TIMEOUT));
  assign timeout_err = terr_q;

  always_comb begin
    cnt_d  = cnt_q;
    terr_d = terr_q;
    if (state_q == START) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      if (!expired) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!wd_event) begin
        terr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          cur_d   = win;
          last_d  = win;
          data_d  = req_data[int'(win)*8 +: 8];
        end
      end
      LOAD:    state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (wd_event || expired) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      data_q  <= '0;
      wd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      data_q  <= data_d;
      wd_q    <= uart_writedone;
    end
  end

  always_comb begin
    grant           = '0;
    done            = '0;
    uart_writestart = 1'b0;
    busy            = (state_q != IDLE);
    if (state_q == LOAD) grant[cur_q] = 1'b1;
    if (state_q == DONE) done[cur_q]  = 1'b1;
    if (state_q == START) uart_writestart = 1'b1;
  end

  assign uart_in = data_q;

endmodule
